// File: rtl/signed_divider_pkg.sv
// Shared types and constants for the 16-bit signed restoring divider.
package signed_divider_pkg;

   localparam int DIV_WIDTH = 16;
   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_restore_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module div_restore_step #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dvd_bit,
   input  logic [WIDTH:0]   div_mag,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;

   // The partial remainder is always below the divisor magnitude, so the
   // restored/subtracted result fits back into WIDTH bits.
   always_comb begin
      shifted = {rem_in, dvd_bit};
      q_bit   = (shifted >= div_mag);
      rem_out = q_bit ? WIDTH'(shifted - div_mag) : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/signed_divider_16bit.sv
// Multi-cycle signed divider (IDLE -> CALC -> FIX), fixed WIDTH+2 latency.
// Optional div_by_zero output enabled by SIGNED_DIVIDER_DIV_ZERO_FLAG_EN.
module signed_divider_16bit
   import signed_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             aclr,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
`ifdef SIGNED_DIVIDER_DIV_ZERO_FLAG_EN
   ,
   output logic             div_by_zero
`endif
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_t       state, next_state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem_acc;
   logic [WIDTH-1:0] shift_q;
   logic [WIDTH-1:0] dividend_r;
   logic [WIDTH:0]   div_mag;
   logic             neg_q, neg_r, zero_div;
   logic [WIDTH:0]   dvd_ext, dsr_ext;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;
   logic             steps_done;

   // Sign-extended to WIDTH+1 bits so |-2^(WIDTH-1)| is representable.
   assign dvd_ext    = {dividend[WIDTH-1], dividend};
   assign dsr_ext    = {divisor[WIDTH-1], divisor};
   assign steps_done = (count == CNT_W'(WIDTH));

   div_restore_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_acc),
      .dvd_bit (shift_q[WIDTH-1]),
      .div_mag (div_mag),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = CALC;
         CALC:    if (steps_done) next_state = FIX;
         FIX:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   // shift_q starts as the dividend magnitude and fills with quotient bits
   // from the right, ending as the quotient magnitude.
   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         count      <= '0;
         rem_acc    <= '0;
         shift_q    <= '0;
         dividend_r <= '0;
         div_mag    <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         zero_div   <= 1'b0;
         done       <= 1'b0;
         quotient   <= '0;
         remainder  <= '0;
`ifdef SIGNED_DIVIDER_DIV_ZERO_FLAG_EN
         div_by_zero <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: if (start) begin
               dividend_r <= dividend;
               neg_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
               neg_r      <= dividend[WIDTH-1];
               zero_div   <= (divisor == '0);
               shift_q    <= WIDTH'(dvd_ext[WIDTH] ? -dvd_ext : dvd_ext);
               div_mag    <= dsr_ext[WIDTH] ? -dsr_ext : dsr_ext;
               rem_acc    <= '0;
               count      <= '0;
            end
            CALC: if (!steps_done) begin
               rem_acc <= step_rem;
               shift_q <= {shift_q[WIDTH-2:0], step_q};
               count   <= count + CNT_W'(1);
            end
            FIX: begin
               done <= 1'b1;
               if (zero_div) begin
                  quotient  <= DIV_ZERO_QUOTIENT;
                  remainder <= dividend_r;
               end else begin
                  quotient  <= neg_q ? -shift_q : shift_q;
                  remainder <= neg_r ? -rem_acc : rem_acc;
               end
`ifdef SIGNED_DIVIDER_DIV_ZERO_FLAG_EN
               div_by_zero <= zero_div;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_signed_divider_16bit.sv
// Self-checking bench: directed vector table, corner sequences, random ops vs model.
module tb_signed_divider_16bit;

   logic        clock = 1'b0;
   logic        aclr;
   logic        start;
   logic [15:0] dividend, divisor;
   logic        busy, done;
   logic [15:0] quotient, remainder;
`ifdef SIGNED_DIVIDER_DIV_ZERO_FLAG_EN
   logic        div_by_zero;
`endif

   int checks = 0;
   int errors = 0;

   signed_divider_16bit #(.WIDTH(16)) dut (
      .clock     (clock),
      .aclr      (aclr),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder)
`ifdef SIGNED_DIVIDER_DIV_ZERO_FLAG_EN
      ,
      .div_by_zero (div_by_zero)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] q;
      logic [15:0] r;
      logic        z;
   } vec_t;

   vec_t vt[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer division truncates toward zero, % follows dividend sign.
   function automatic void model(input logic signed [15:0] a, input logic signed [15:0] b,
                                 output logic [15:0] q, output logic [15:0] r);
      int ai, bi;
      ai = a;
      bi = b;
      if (bi == 0) begin
         q = 16'hFFFF;
         r = a;
      end else begin
         q = 16'(ai / bi);
         r = 16'(ai % bi);
      end
   endfunction

   // Called #1 after a rising edge; returns cycles from sampling edge to done.
   task automatic issue(input logic [15:0] a, input logic [15:0] b, output int lat,
                        output logic busy1);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      busy1 = busy;
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(posedge clock);
         #1;
         if (done) lat = k;
      end
   endtask

   initial begin
      int lat, ndone;
      logic b1;
      logic [15:0] eq, er, a, b, hold_q;

      vt[0]  = '{16'd100,   16'd7,     16'd14,    16'd2,     1'b0};
      vt[1]  = '{16'hFF9C,  16'd7,     16'hFFF2,  16'hFFFE,  1'b0};
      vt[2]  = '{16'd100,   16'hFFF9,  16'hFFF2,  16'd2,     1'b0};
      vt[3]  = '{16'd100,   16'd0,     16'hFFFF,  16'd100,   1'b1};
      vt[4]  = '{16'h8000,  16'hFFFF,  16'h8000,  16'd0,     1'b0};
      vt[5]  = '{16'h8000,  16'd1,     16'h8000,  16'd0,     1'b0};
      vt[6]  = '{16'd0,     16'd5,     16'd0,     16'd0,     1'b0};
      vt[7]  = '{16'd7,     16'd100,   16'd0,     16'd7,     1'b0};
      vt[8]  = '{16'hFFF9,  16'd100,   16'd0,     16'hFFF9,  1'b0};
      vt[9]  = '{16'h7FFF,  16'h8000,  16'd0,     16'h7FFF,  1'b0};
      vt[10] = '{16'h8000,  16'h8000,  16'd1,     16'd0,     1'b0};
      vt[11] = '{16'h8000,  16'd0,     16'hFFFF,  16'h8000,  1'b1};
      vt[12] = '{16'hFFFF,  16'd0,     16'hFFFF,  16'hFFFF,  1'b1};
      vt[13] = '{16'h7FFF,  16'd2,     16'h3FFF,  16'd1,     1'b0};
      vt[14] = '{16'h8001,  16'd2,     16'hC001,  16'hFFFF,  1'b0};
      vt[15] = '{16'h7FFF,  16'hFFFF,  16'h8001,  16'd0,     1'b0};

      aclr = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_q", quotient, 0);
      check("reset_r", remainder, 0);
`ifdef SIGNED_DIVIDER_DIV_ZERO_FLAG_EN
      check("reset_dbz", div_by_zero, 0);
`endif
      aclr = 1'b0;
      @(posedge clock);
      #1;

      foreach (vt[i]) begin
         issue(vt[i].a, vt[i].b, lat, b1);
         check($sformatf("vec%0d_busy", i), b1, 1);
         check($sformatf("vec%0d_latency", i), lat, 18);
         check($sformatf("vec%0d_q", i), quotient, vt[i].q);
         check($sformatf("vec%0d_r", i), remainder, vt[i].r);
`ifdef SIGNED_DIVIDER_DIV_ZERO_FLAG_EN
         check($sformatf("vec%0d_dbz", i), div_by_zero, vt[i].z);
`endif
         @(posedge clock);
         #1;
         check($sformatf("vec%0d_done_pulse", i), done, 0);
      end

      // Start while busy is ignored; outputs hold through CALC; back-to-back in done cycle.
      hold_q = quotient;
      dividend = 16'd50; divisor = 16'd5; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      ndone = 0; lat = 0;
      for (int k = 1; k <= 18; k++) begin
         @(posedge clock);
         #1;
         start = 1'b0;
         if (k == 4) begin
            dividend = 16'd9; divisor = 16'd3; start = 1'b1;
         end
         if (k == 10) check("hold_q_in_calc", quotient, hold_q);
         if (done) begin ndone++; lat = k; end
      end
      check("ignored_start_done_count", ndone, 1);
      check("ignored_start_latency", lat, 18);
      check("ignored_start_q", quotient, 10);
      issue(16'd9, 16'd3, lat, b1);
      check("b2b_latency", lat, 18);
      check("b2b_q", quotient, 3);
      check("b2b_r", remainder, 0);

      // Asynchronous abort mid-operation, then a clean retry.
      dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      repeat (8) @(posedge clock);
      #1 aclr = 1'b1;
      #2;
      check("abort_busy", busy, 0);
      check("abort_q", quotient, 0);
      check("abort_r", remainder, 0);
      @(posedge clock);
      #1 aclr = 1'b0;
      ndone = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clock);
         #1;
         if (done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      issue(16'd1000, 16'd3, lat, b1);
      check("retry_latency", lat, 18);
      check("retry_q", quotient, 333);
      check("retry_r", remainder, 1);

      for (int n = 0; n < 150; n++) begin
         a = 16'($urandom);
         b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
         if ($urandom_range(0, 9) == 0) a = 16'h8000;
         if ($urandom_range(0, 9) == 0) b = 16'($urandom_range(0, 1) ? 1 : 16'hFFFF);
         model(a, b, eq, er);
         issue(a, b, lat, b1);
         check($sformatf("rnd%0d_latency", n), lat, 18);
         check($sformatf("rnd%0d_q %0h/%0h", n, a, b), quotient, eq);
         check($sformatf("rnd%0d_r %0h/%0h", n, a, b), remainder, er);
`ifdef SIGNED_DIVIDER_DIV_ZERO_FLAG_EN
         check($sformatf("rnd%0d_dbz", n), div_by_zero, (b == 16'd0));
`endif
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
